// File: rtl/ps2_scan_rx_if.sv
// Key-event stream from the PS/2 receiver to the scan-code lookup stage.
// The master (receiver) presents the head FIFO entry, and the slave accepts it with out_ready.
interface ps2_scan_rx_if;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_code;
   logic       out_ext;
   logic       out_break;

   modport master (
      output out_valid,
      output out_code,
      output out_ext,
      output out_break,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_code,
      input  out_ext,
      input  out_break,
      output out_ready
   );
endinterface

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: it synchronises the pins, deframes and checks 11-bit frames, folds E0/F0
// prefixes into flags and queues each key event in a first-word-fall-through FIFO.
module ps2_scan_rx #(
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT    = 4096
) (
   input  logic          clk,
   input  logic          clrn,
   input  logic          ps2_clk,
   input  logic          ps2_data,
   ps2_scan_rx_if.master evt,
   output logic          frame_err,
   output logic          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK
   } decState_e;

   logic [2:0]    clkSync_q;
   logic [1:0]    dataSync_q;
   logic [3:0]    bitCnt_q;
   logic [9:0]    shift_q;
   logic [CW-1:0] cycleCnt_q;
   logic          frameErr_q;
   decState_e     state_q;
   logic          push_q;
   logic [9:0]    pushData_q;
   logic [9:0]    mem_q [FIFO_DEPTH];
   logic [AW:0]   wrPtr_q;
   logic [AW:0]   rdPtr_q;
   logic          overflow_q;

   logic       fallEdge;
   logic       dataBit;
   logic       frameDone;
   logic       frameOk;
   logic [7:0] byteIn;
   logic       curExt;
   logic       curBrk;
   logic       fifoEmpty;
   logic       fifoFull;
   logic       pop;
   logic       doPush;
   logic [9:0] head;

   // The two oldest clock flops form the edge detector, and the data pin is sampled in that same cycle.
   assign fallEdge  = clkSync_q[2] & ~clkSync_q[1];
   assign dataBit   = dataSync_q[1];
   assign frameDone = fallEdge && (bitCnt_q == 4'd10);
   // shift_q holds start in [0], data in [8:1] and parity in [9]. The stop bit is still on the wire.
   assign frameOk   = frameDone && !shift_q[0] && dataBit && (^shift_q[9:1]);
   assign byteIn    = shift_q[8:1];

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         clkSync_q  <= 3'b111;
         dataSync_q <= 2'b11;
         bitCnt_q   <= 4'd0;
         shift_q    <= '0;
         cycleCnt_q <= '0;
         frameErr_q <= 1'b0;
      end else begin
         clkSync_q  <= {clkSync_q[1:0], ps2_clk};
         dataSync_q <= {dataSync_q[0], ps2_data};
         frameErr_q <= frameDone && !frameOk;
         if (fallEdge) begin
            cycleCnt_q <= '0;
            if (bitCnt_q == 4'd10) begin
               bitCnt_q <= 4'd0;
            end else begin
               bitCnt_q <= bitCnt_q + 4'd1;
               shift_q  <= {dataBit, shift_q[9:1]};
            end
         end else begin
            if (cycleCnt_q != CW'(TIMEOUT)) begin
               cycleCnt_q <= cycleCnt_q + CW'(1);
            end else if (bitCnt_q != 4'd0) begin
               bitCnt_q <= 4'd0;
            end
         end
      end
   end

   assign curExt = (state_q == EXT) || (state_q == EXT_BRK);
   assign curBrk = (state_q == BRK) || (state_q == EXT_BRK);

   // Prefix bytes only change the flags. Any other byte emits an event with the current flags and clears them.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q    <= IDLE;
         push_q     <= 1'b0;
         pushData_q <= '0;
      end else begin
         push_q <= 1'b0;
         if (frameOk) begin
            case (byteIn)
               8'hE0: begin
                  if (state_q == IDLE) state_q <= EXT;
                  else if (state_q == BRK) state_q <= EXT_BRK;
               end
               8'hF0: begin
                  if (state_q == IDLE) state_q <= BRK;
                  else if (state_q == EXT) state_q <= EXT_BRK;
               end
               default: begin
                  push_q     <= 1'b1;
                  pushData_q <= {curExt, curBrk, byteIn};
                  state_q    <= IDLE;
               end
            endcase
         end
      end
   end

   assign fifoEmpty = (wrPtr_q == rdPtr_q);
   assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign pop       = !fifoEmpty && evt.out_ready;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is kept in that case.
   assign doPush    = push_q && (!fifoFull || pop);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (doPush) begin
            mem_q[wrPtr_q[AW-1:0]] <= pushData_q;
            wrPtr_q                <= wrPtr_q + 1'b1;
         end
         if (pop) rdPtr_q <= rdPtr_q + 1'b1;
         if (push_q && fifoFull && !pop) overflow_q <= 1'b1;
      end
   end

   assign head          = mem_q[rdPtr_q[AW-1:0]];
   assign evt.out_valid = !fifoEmpty;
   assign evt.out_code  = head[7:0];
   assign evt.out_break = head[8];
   assign evt.out_ext   = head[9];
   assign frame_err     = frameErr_q;
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Scoreboard bench for ps2_scan_rx: directed PS/2 frames queue their hand-computed events,
// and a monitor pops and compares each accepted output entry.
module tb_ps2_scan_rx;

   localparam int DEPTH = 8;
   localparam int TMO   = 4096;

   logic clk     = 1'b0;
   logic clrn    = 1'b0;
   logic ps2Clk  = 1'b1;
   logic ps2Data = 1'b1;
   logic frameErr;
   logic overflow;

   ps2_scan_rx_if evt ();

   ps2_scan_rx #(
      .FIFO_DEPTH(DEPTH),
      .TIMEOUT   (TMO)
   ) dut (
      .clk      (clk),
      .clrn     (clrn),
      .ps2_clk  (ps2Clk),
      .ps2_data (ps2Data),
      .evt      (evt),
      .frame_err(frameErr),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   int         vectors      = 0;
   int         miscompares  = 0;
   int         frameErrSeen = 0;
   logic [9:0] expQ[$];
   logic [9:0] monExp;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // The monitor counts frame_err pulses and checks every accepted entry against the head of the scoreboard.
   always @(negedge clk) begin
      if (clrn) begin
         if (frameErr) frameErrSeen++;
         if (evt.out_valid && evt.out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected entry", {22'd0, evt.out_ext, evt.out_break, evt.out_code}, 32'hFFFF_FFFF);
            end else begin
               monExp = expQ.pop_front();
               checkOutput("entry", {22'd0, evt.out_ext, evt.out_break, evt.out_code}, {22'd0, monExp});
            end
         end
      end
   end

   // Frame order is start, 8 data bits LSB first, odd parity, stop. mode 1 measures the stop-edge-to-valid latency.
   // mode 2 pulses out_ready in the cycle where the decoded event is pushed.
   task automatic applyStimulus(input logic [7:0] b, input bit badPar, input bit badStop, input int mode);
      logic [10:0] bits;
      int          lat;
      bits = {~badStop, (~^b) ^ badPar, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         ps2Data = bits[i];
         repeat (10) @(negedge clk);
         ps2Clk = 1'b0;
         if (i == 10 && mode == 1) begin
            lat = 0;
            while (!evt.out_valid && lat < 20) begin
               @(negedge clk);
               lat++;
            end
            checkOutput("make latency", lat, 4);
         end else if (i == 10 && mode == 2) begin
            repeat (3) @(posedge clk);
            #1 evt.out_ready = 1'b1;
            @(posedge clk);
            #1 evt.out_ready = 1'b0;
         end
         repeat (20) @(negedge clk);
         ps2Clk = 1'b1;
         repeat (10) @(negedge clk);
      end
      ps2Data = 1'b1;
   endtask

   task automatic sendPartial(input int n);
      logic [10:0] bits;
      bits = {1'b1, 1'b0, 8'h1C, 1'b0};
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ps2Data = bits[i];
         repeat (10) @(negedge clk);
         ps2Clk = 1'b0;
         repeat (20) @(negedge clk);
         ps2Clk = 1'b1;
         repeat (10) @(negedge clk);
      end
      ps2Data = 1'b1;
   endtask

   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while ((expQ.size() != 0 || evt.out_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, " pending"}, expQ.size(), 0);
      checkOutput({name, " valid"}, {31'd0, evt.out_valid}, 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      evt.out_ready = 1'b1;
      clrn = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset valid", {31'd0, evt.out_valid}, 0);
      checkOutput("reset code", {24'd0, evt.out_code}, 0);
      checkOutput("reset frame_err", {31'd0, frameErr}, 0);
      checkOutput("reset overflow", {31'd0, overflow}, 0);
      clrn = 1'b1;
      repeat (5) @(negedge clk);

      // A single make code, with its pipeline latency measured.
      expQ.push_back({2'b00, 8'h1C});
      applyStimulus(8'h1C, 0, 0, 1);
      checkOutput("make frame_err", frameErrSeen, 0);
      waitDrain("make");

      // Break, extended and extended-break sequences.
      expQ.push_back({2'b01, 8'h1C});
      applyStimulus(8'hF0, 0, 0, 0);
      applyStimulus(8'h1C, 0, 0, 0);
      expQ.push_back({2'b10, 8'h75});
      applyStimulus(8'hE0, 0, 0, 0);
      applyStimulus(8'h75, 0, 0, 0);
      expQ.push_back({2'b11, 8'h75});
      applyStimulus(8'hE0, 0, 0, 0);
      applyStimulus(8'hF0, 0, 0, 0);
      applyStimulus(8'h75, 0, 0, 0);
      waitDrain("prefix");

      // Rejected frames leave the prefix state untouched and push nothing.
      expQ.push_back({2'b10, 8'h75});
      applyStimulus(8'hE0, 0, 0, 0);
      applyStimulus(8'hF0, 1, 0, 0);
      checkOutput("parity err count", frameErrSeen, 1);
      applyStimulus(8'h12, 0, 1, 0);
      checkOutput("stop err count", frameErrSeen, 2);
      applyStimulus(8'h75, 0, 0, 0);
      expQ.push_back({2'b11, 8'h75});
      applyStimulus(8'hE0, 0, 0, 0);
      applyStimulus(8'hF0, 0, 0, 0);
      applyStimulus(8'h33, 1, 0, 0);
      applyStimulus(8'h75, 0, 0, 0);
      checkOutput("err count after prefix", frameErrSeen, 3);
      waitDrain("errors");

      // A truncated frame times out silently.
      sendPartial(5);
      repeat (TMO + 2) @(negedge clk);
      expQ.push_back({2'b00, 8'h1C});
      applyStimulus(8'h1C, 0, 0, 0);
      checkOutput("timeout frame_err", frameErrSeen, 3);
      waitDrain("timeout");

      // Backpressure: nine makes into eight slots, so the last one is dropped.
      evt.out_ready = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         if (k <= 8) expQ.push_back({2'b00, 8'(k)});
         applyStimulus(8'(k), 0, 0, 0);
      end
      repeat (10) @(negedge clk);
      checkOutput("overflow set", {31'd0, overflow}, 1);
      checkOutput("full valid", {31'd0, evt.out_valid}, 1);
      checkOutput("held head", {24'd0, evt.out_code}, 32'h01);
      evt.out_ready = 1'b1;
      waitDrain("overflow drain");
      checkOutput("overflow sticky", {31'd0, overflow}, 1);

      // Reset in the middle of a frame, with an entry queued and a pending E0.
      evt.out_ready = 1'b0;
      applyStimulus(8'h2A, 0, 0, 0);
      applyStimulus(8'hE0, 0, 0, 0);
      sendPartial(6);
      @(negedge clk);
      clrn = 1'b0;
      #1;
      checkOutput("midreset valid", {31'd0, evt.out_valid}, 0);
      checkOutput("midreset code", {24'd0, evt.out_code}, 0);
      checkOutput("midreset ext", {31'd0, evt.out_ext}, 0);
      checkOutput("midreset break", {31'd0, evt.out_break}, 0);
      checkOutput("midreset overflow", {31'd0, overflow}, 0);
      checkOutput("midreset frame_err", {31'd0, frameErr}, 0);
      repeat (5) @(negedge clk);
      clrn = 1'b1;
      evt.out_ready = 1'b1;
      repeat (5) @(negedge clk);
      expQ.push_back({2'b00, 8'h1C});
      applyStimulus(8'h1C, 0, 0, 0);
      checkOutput("post-reset frame_err", frameErrSeen, 3);
      waitDrain("post-reset");

      // A push and a pop in the same cycle while full: nothing is dropped.
      evt.out_ready = 1'b0;
      for (int k = 8'h11; k <= 8'h18; k++) begin
         expQ.push_back({2'b00, 8'(k)});
         applyStimulus(8'(k), 0, 0, 0);
      end
      repeat (10) @(negedge clk);
      expQ.push_back({2'b00, 8'h19});
      applyStimulus(8'h19, 0, 0, 2);
      repeat (10) @(negedge clk);
      checkOutput("push-pop overflow", {31'd0, overflow}, 0);
      checkOutput("push-pop head", {24'd0, evt.out_code}, 32'h12);
      checkOutput("push-pop pending", expQ.size(), 8);
      evt.out_ready = 1'b1;
      waitDrain("push-pop drain");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ps2_scan_rx.md
# ps2_scan_rx

PS/2 keyboard receive stage that produces the 8-bit scan codes consumed by the downstream key-lookup mux (scan code → ASCII / segment pattern). It samples the raw `ps2_clk`/`ps2_data` pins, deframes and checks 11-bit PS/2 frames, and folds `E0`/`F0` prefixes into flags. Each completed key event is queued in a small FIFO and presented on a valid/ready interface. One clock domain; the PS/2 pins are asynchronous inputs.

## Interface
- `FIFO_DEPTH`, 8: event queue entries; power of two, ≥2.
- `TIMEOUT`, 4096: clk cycles without a PS/2 falling edge, mid-frame, before the frame is abandoned.

- `clk`  in  1  system clock
- `clrn`  in  1  asynchronous, active-low reset
- `ps2_clk`  in  1  raw PS/2 clock pin (async)
- `ps2_data`  in  1  raw PS/2 data pin (async)
- `out_ready`  in  1  consumer accepts head entry
- `out_valid`  out  1  FIFO non-empty
- `out_code`  out  8  scan code of head entry
- `out_ext`  out  1  head entry was `E0`-prefixed
- `out_break`  out  1  head entry is a release (`F0`-prefixed)
- `frame_err`  out  1  one-cycle pulse per rejected frame
- `overflow`  out  1  sticky: an event was dropped because the FIFO was full

## Operation
- Input sync: 3-flop chain on `ps2_clk` and 2-flop chain on `ps2_data`. A falling edge is declared when the two oldest `ps2_clk` flops read 1 then 0. `ps2_data` is sampled from its synchronised value in the edge-detect cycle.
- Frame shift: a 4-bit bit counter runs 0..10.
  - Bit 0 is start, bits 1–8 are data (LSB first), bit 9 is parity, bit 10 is stop.
  - On bit 10 the frame is accepted only if start==0, stop==1 and XOR(data, parity)==1 (odd parity).
  - The counter returns to 0 after bit 10 regardless of the check result.
- Rejected frame: `frame_err` is high for exactly 1 cycle, the byte is discarded, and decoder state is unchanged.
- Timeout: a cycle counter clears on every falling edge. If the bit counter is nonzero and the cycle counter reaches `TIMEOUT`, the bit counter resets to 0 silently, with no `frame_err`.
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions on each accepted byte:
  - `E0`: IDLE→EXT, BRK→EXT_BRK, EXT/EXT_BRK unchanged.
  - `F0`: IDLE→BRK, EXT→EXT_BRK, BRK/EXT_BRK unchanged.
  - Any other byte: push {ext, brk, code} using the current state's flags, then go to IDLE.
- FIFO: first-word-fall-through, write pointer and read pointer each one bit wider than the address.
  - Pop happens when `out_valid && out_ready`.
  - Push while full (and no pop that cycle): the entry is dropped and `overflow` is set to 1. It stays 1 until `clrn`.
  - Push and pop in the same cycle while full: both take effect, nothing is dropped, occupancy is unchanged.
  - Push and pop in the same cycle while empty: impossible, since an empty FIFO has `out_valid`=0.
- Output hold: while `out_valid && !out_ready`, `out_code`/`out_ext`/`out_break` stay stable. When `out_valid`=0 their values are don't-care.

## Timing
- Reset (`clrn` low, async): all outputs 0, FIFO empty, counters 0, FSM IDLE, sync flops 1 (idle bus).
- Reset mid-frame or mid-prefix: the partial frame and any pending flags are discarded. Reception resumes at the next start bit after release.
- Latency: pin falling edge → edge detect takes 3 cycles (cycle T). For the stop bit at T, the FIFO write occurs at T+1 and `out_valid` rises at T+2.
- `frame_err` pulses at T+1 relative to the stop-bit edge detect.
- Pointers wrap modulo 2·`FIFO_DEPTH`. Full = MSBs differ and the rest are equal; empty = pointers equal.
- Min `clk` ≥ 10× PS/2 clock (≤16.7 kHz) is required. The block does not guarantee behaviour below that ratio.

## Test plan
- Single make: frame for `1C` (A) → one entry {code=`1C`, ext=0, break=0}. `out_valid` rises 2 cycles after the stop edge is detected; `frame_err` stays 0.
- Break and extended sequence: bytes `F0 1C`, `E0 75`, `E0 F0 75` → three entries `{1C,0,1}`, `{75,1,0}`, `{75,1,1}` in order.
- Errors: a frame with bad parity, then one with stop=0 → `frame_err` pulses once for each, no entry is pushed, and a following `E0 F0` prefix state is unaffected.
- Timeout: send 5 bits, idle `TIMEOUT`+2 cycles, then a full `1C` frame → exactly one entry `{1C,0,0}`, no `frame_err`.
- Overflow/backpressure: hold `out_ready`=0 and send 9 makes `01`..`09` with depth 8 → entries `01`..`08` retained, `09` dropped, `overflow`=1. Then set `out_ready`=1 → 8 entries drain in order, `out_valid` falls after `08`, `overflow` stays 1.
- Simultaneous push/pop at full, and `clrn` asserted mid-frame → no drop and occupancy stays 8. After `clrn`, all outputs are 0 and the next complete frame decodes correctly.
